// File: rtl/dmem_responder.sv
// Data-memory responder: one word load/store per handshake, WAIT_CYCLES wait states, one-cycle response strobe.
// Latency: response WAIT_CYCLES+1 edges after acceptance. Backpressure: req_ready low while in flight, no queueing.
// Optional DMEM_RESPONDER_PERF_EN adds rd_count/wr_count for successful accesses.
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
`ifdef DMEM_RESPONDER_PERF_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic          w_accept;
    logic          w_access;
    logic          w_err;
    logic [AW-1:0] w_idx;

    assign w_accept  = req_valid && (r_state == S_IDLE);
    assign w_access  = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_err     = (r_addr[1:0] != 2'b00) || (r_addr >= LIMIT);
    assign w_idx     = r_addr[AW+1:2];

    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt   <= 4'(WAIT_CYCLES);
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Stores leave rsp_rdata holding the last load result.
            if (w_access) begin
                r_err <= w_err;
                if (w_err)
                    r_rdata <= 32'd0;
                else if (!r_we)
                    r_rdata <= r_mem[w_idx];
            end
        end
    end

    // Array has no reset; a reset during WAIT keeps w_access low so nothing commits.
    always_ff @(posedge clk) begin
        if (w_access && r_we && !w_err)
            r_mem[w_idx] <= r_wdata;
    end

`ifdef DMEM_RESPONDER_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count <= 32'd0;
            wr_count <= 32'd0;
        end else if (w_access && !w_err) begin
            if (r_we)
                wr_count <= wr_count + 32'd1;
            else
                rd_count <= rd_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: WAIT_CYCLES=2 instance for function/backpressure/reset,
// plus a WAIT_CYCLES=0 instance for minimum latency.
module tb_dmem_responder;
    localparam int W = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        z_valid, z_ready, z_we;
    logic [31:0] z_addr, z_wdata;
    logic        z_rvld, z_err, z_busy;
    logic [31:0] z_rdata;

`ifdef DMEM_RESPONDER_PERF_EN
    logic [31:0] rd_count, wr_count, z_rd_count, z_wr_count;
`endif

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
`ifdef DMEM_RESPONDER_PERF_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_valid), .req_ready(z_ready), .req_we(z_we),
        .req_addr(z_addr), .req_wdata(z_wdata),
        .rsp_valid(z_rvld), .rsp_rdata(z_rdata), .rsp_err(z_err), .busy(z_busy)
`ifdef DMEM_RESPONDER_PERF_EN
        , .rd_count(z_rd_count), .wr_count(z_wr_count)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;
    int exp_rd = 0;
    int exp_wr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with req_valid dropped.
    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int t;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        int j;
        j = 0;
        while (!rsp_valid && j < 50) begin
            @(negedge clk);
            j++;
        end
        lat = j;
    endtask

    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rdata);
        int lat;
        send(we, addr, wdata);
        wait_rsp(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(W + 1));
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
        if (!exp_err) begin
            if (we) exp_wr++;
            else    exp_rd++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int pulses;
        reset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        z_valid = 1'b0; z_we = 1'b0; z_addr = 32'd0; z_wdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rvld", 32'(rsp_valid), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        txn("st10",  1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0);
        txn("ld10",  1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF);
        txn("st13",  1'b1, 32'h13,  32'h12345678, 1'b1, 32'h0);
        txn("ld10b", 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF);
        txn("stfc",  1'b1, 32'hFC,  32'hCAFEF00D, 1'b0, 32'hDEADBEEF);
        txn("ld100", 1'b0, 32'h100, 32'h0,        1'b1, 32'h0);
        txn("ldfc",  1'b0, 32'hFC,  32'h0,        1'b0, 32'hCAFEF00D);
        txn("ldhi",  1'b0, 32'h80000010, 32'h0,   1'b1, 32'h0);

        // Backpressure: second request held while busy, fields of the first must not change.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hA5A50001;
        @(posedge clk);
        @(negedge clk);
        req_we = 1'b0; req_wdata = 32'hFFFFFFFF;
        for (int j = 0; j < W + 2; j++) begin
            chk("bp_ready_low", 32'(req_ready), 32'd0);
            if (j == W + 1) chk("bp_first_rsp", 32'(rsp_valid), 32'd1);
            @(negedge clk);
        end
        chk("bp_ready_idle", 32'(req_ready), 32'd1);
        exp_wr++;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(lat);
        chk("bp_ld_lat", 32'(lat), 32'(W + 1));
        chk("bp_ld_rdata", rsp_rdata, 32'hA5A50001);
        chk("bp_ld_err", 32'(rsp_err), 32'd0);
        exp_rd++;
        @(negedge clk);

        // Reset during WAIT aborts the store.
        txn("st20", 1'b1, 32'h20, 32'h11112222, 1'b0, 32'hA5A50001);
        send(1'b1, 32'h20, 32'h55AA55AA);
        chk("abort_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_busy_rst", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_rd = 0;
        exp_wr = 0;
        pulses = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        chk("abort_no_rsp", 32'(pulses), 32'd0);
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        txn("ld20", 1'b0, 32'h20, 32'h0, 1'b0, 32'h11112222);
        txn("ld20b", 1'b0, 32'h20, 32'h0, 1'b0, 32'h11112222);
        txn("st24", 1'b1, 32'h24, 32'h00000024, 1'b0, 32'h11112222);
        txn("ld24", 1'b0, 32'h24, 32'h0, 1'b0, 32'h00000024);
        txn("st25", 1'b1, 32'h25, 32'h0, 1'b1, 32'h0);

`ifdef DMEM_RESPONDER_PERF_EN
        chk("perf_rd", rd_count, 32'(exp_rd));
        chk("perf_wr", wr_count, 32'(exp_wr));
`endif

        // WAIT_CYCLES=0 instance: one WAIT cycle, response on the next edge.
        z_valid = 1'b1; z_we = 1'b1; z_addr = 32'h4; z_wdata = 32'h0BADF00D;
        @(posedge clk);
        @(negedge clk);
        z_valid = 1'b0;
        chk("w0_st_wait", 32'(z_rvld), 32'd0);
        chk("w0_st_busy", 32'(z_busy), 32'd1);
        @(negedge clk);
        chk("w0_st_rsp", 32'(z_rvld), 32'd1);
        chk("w0_st_err", 32'(z_err), 32'd0);
        @(negedge clk);
        chk("w0_st_idle", 32'(z_ready), 32'd1);
        z_valid = 1'b1; z_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        z_valid = 1'b0;
        chk("w0_ld_wait", 32'(z_rvld), 32'd0);
        @(negedge clk);
        chk("w0_ld_rsp", 32'(z_rvld), 32'd1);
        chk("w0_ld_rdata", z_rdata, 32'h0BADF00D);
        @(negedge clk);
        chk("w0_ld_pulse", 32'(z_rvld), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the kodd core's load/store port: the target end of the processor's data-access interface.
- Accepts one word read or write per valid/ready handshake and inserts a programmable number of wait states.
- Returns read data or an error flag through a one-cycle response strobe.
- Replaces the zero-latency data memory when the system needs realistic memory timing.

Parameters:
- DEPTH, 64, number of 32-bit words stored; power of two, at least 2.
- WAIT_CYCLES, 2, wait states between request acceptance and response; range 0..15.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  32  load data.
- rsp_err  output  1  request was rejected (misaligned or out of range); qualified by rsp_valid.
- busy  output  1  a request is in flight.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, counter 0, all outputs 0 except req_ready=1. Memory array is not reset.
- States: IDLE, WAIT, RESP.
- req_ready = (state==IDLE). busy = (state!=IDLE).
- Acceptance: rising edge with req_valid && req_ready.
  - Latch we, addr and wdata into internal registers.
  - Load counter = WAIT_CYCLES.
  - Go to WAIT.
- WAIT:
  - If counter!=0, decrement and stay in WAIT.
  - If counter==0, next edge goes to RESP and performs the access using the latched fields.
- Access, at the edge entering RESP:
  - Word index = addr[log2(DEPTH)+1:2].
  - err = (addr[1:0]!=0) || (addr >= DEPTH*4).
  - Store with err=0: write wdata to mem[index]; rsp_rdata unchanged.
  - Load with err=0: rsp_rdata <= mem[index].
  - err=1: no write; rsp_rdata <= 0; rsp_err <= 1.
  - rsp_err <= err on every access.
- RESP: rsp_valid=1 for exactly this one cycle; next edge returns to IDLE.
- Latency: request accepted at edge N gives rsp_valid high between edges N+WAIT_CYCLES+1 and N+WAIT_CYCLES+2.
- Throughput: next acceptance no earlier than edge N+WAIT_CYCLES+3.
- rsp_rdata and rsp_err hold their values until the next access; rsp_valid is a pulse.
- req_valid while busy: ignored and not queued. The initiator must keep req_valid asserted, with stable fields, until it sees req_ready.
- Latched request fields are immune to input changes after acceptance.
- Reset during WAIT: the request is aborted, no memory write occurs, and no response is issued.
- Reset during RESP: the write has already committed; the response strobe is cut short.
- WAIT_CYCLES=0: the machine spends exactly one cycle in WAIT (counter already 0).

Optional Feature:
- Macro: DMEM_RESPONDER_PERF_EN.
- When defined, adds outputs rd_count[31:0] and wr_count[31:0].
  - Each counter increments at the edge entering RESP for a successful load or store respectively; erroneous accesses are not counted.
  - Counters wrap from 0xFFFFFFFF to 0 and reset to 0.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Store then load, WAIT_CYCLES=2: store addr 0x10, data 0xDEADBEEF accepted at edge 5 → rsp_valid during cycle 8–9, rsp_err=0. Load addr 0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0.
- Misaligned access: store addr 0x13 → rsp_err=1, rsp_rdata=0. A following load of 0x10 still returns the prior 0xDEADBEEF.
- Out of range, DEPTH=64: load addr 0x100 → rsp_err=1, rsp_rdata=0. Load addr 0xFC (last word) → rsp_err=0.
- Back-pressure: hold req_valid high with a second request while busy=1 → req_ready=0 until IDLE. The second request is accepted exactly at edge N+WAIT_CYCLES+3. Changing req_wdata mid-flight does not alter the committed first write.
- Reset mid-WAIT: store 0x55AA55AA to addr 0x20, pull reset low during WAIT → no rsp_valid, req_ready=1 after release. Load 0x20 returns the value written before the aborted store.
- Perf counters (with DMEM_RESPONDER_PERF_EN) after 3 good loads, 2 good stores and 1 error access → rd_count=3, wr_count=2. WAIT_CYCLES=0 build: response appears one edge after the single WAIT cycle.
